// File: rtl/nyan_keys_pkg.sv
// Shared types and width helpers for the key debounce/event front end.
// Key-change events are {key index, pressed} with a fixed-width index field trimmed at the top.
package nyan_keys_pkg;

  localparam int KEY_IDX_W_MAX = 16;

  localparam logic PRESS   = 1'b1;
  localparam logic RELEASE = 1'b0;

  function automatic int key_w(input int keys);
    return (keys > 1) ? $clog2(keys) : 1;
  endfunction

  function automatic int cnt_w(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

  typedef struct packed {
    logic [KEY_IDX_W_MAX-1:0] key;
    logic                     pressed;
  } key_evt_t;

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event FIFO; head visible the clock after a push into an empty queue.
// Push is refused while the registered count equals DEPTH, even if a pop occurs that same cycle.
module key_evt_fifo
  import nyan_keys_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  key_evt_t                 push_dat_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output key_evt_t                 pop_dat_o,
  output logic                     pop_vld_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  key_evt_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign pop_vld_o = (count_q != '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && pop_vld_o;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never read while empty, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/key_debounce_events.sv
// Per-key synchroniser + integrating debouncer; keys_o follows a clean edge SYNC_STAGES+DEBOUNCE_CYCLES clocks later.
// A rotating scanner moves pending changes into the event FIFO; a full FIFO holds them pending without loss.
module key_debounce_events
  import nyan_keys_pkg::*;
#(
  parameter int  KEYS            = 61,
  parameter int  DEBOUNCE_CYCLES = 120000,
  parameter int  SYNC_STAGES     = 2,
  parameter int  FIFO_DEPTH      = 16,
  parameter bit  ACTIVE_LOW      = 1'b0,
  localparam int KEY_W           = key_w(KEYS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [KEYS-1:0]             keys_i,
  output logic [KEYS-1:0]             keys_o,
  output logic                        evt_valid_o,
  input  logic                        evt_ready_i,
  output logic [KEY_W-1:0]            evt_key_o,
  output logic                        evt_pressed_o,
  output logic [$clog2(FIFO_DEPTH):0] evt_count_o,
  output logic                        evt_lost_o,
  input  logic                        lost_clr_i
);

  localparam int               CNT_W    = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [KEY_W-1:0] P_LAST   = KEY_W'(KEYS - 1);

  logic [KEYS-1:0]                  keys_raw;
  logic [SYNC_STAGES-1:0][KEYS-1:0] sync_q;
  logic [KEYS-1:0]                  keys_s;
  logic [KEYS-1:0]                  keys_q, keys_d;
  logic [KEYS-1:0]                  pending_q, pending_d;
  logic [KEYS-1:0]                  dir_q, dir_d;
  logic [KEYS-1:0]                  toggle, consume, lost_hit;
  logic [KEY_W-1:0]                 scan_q, scan_d;
  logic                             lost_q, lost_d;
  logic                             fifo_full, push;
  key_evt_t                         push_dat, head;
  logic                             unused_head_key;

  assign keys_raw = ACTIVE_LOW ? ~keys_i : keys_i;
  assign keys_s   = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= keys_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  for (genvar k = 0; k < KEYS; k++) begin : g_key
    logic             differ;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign differ       = keys_s[k] ^ keys_q[k];
    assign toggle[k]    = differ && (cnt_q == CNT_LAST);
    assign cnt_d        = (!differ || toggle[k]) ? '0 : cnt_q + CNT_W'(1);
    assign keys_d[k]    = keys_q[k] ^ toggle[k];
    assign consume[k]   = push && (scan_q == KEY_W'(k));
    // A toggle in the same cycle the scanner consumes this key re-arms it rather than losing anything.
    assign pending_d[k] = toggle[k] | (pending_q[k] & ~consume[k]);
    assign dir_d[k]     = toggle[k] ? keys_d[k] : dir_q[k];
    assign lost_hit[k]  = toggle[k] & pending_q[k] & ~consume[k];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end
  end

  assign scan_d   = (scan_q == P_LAST) ? '0 : scan_q + KEY_W'(1);
  assign push     = pending_q[scan_q] && !fifo_full;
  assign push_dat = '{key: KEY_IDX_W_MAX'(scan_q), pressed: dir_q[scan_q]};
  assign lost_d   = (|lost_hit) ? 1'b1 : (lost_clr_i ? 1'b0 : lost_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      keys_q    <= '0;
      pending_q <= '0;
      dir_q     <= '0;
      scan_q    <= '0;
      lost_q    <= 1'b0;
    end else begin
      keys_q    <= keys_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      scan_q    <= scan_d;
      lost_q    <= lost_d;
    end
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .push_dat_i (push_dat),
    .full_o     (fifo_full),
    .pop_i      (evt_ready_i),
    .pop_dat_o  (head),
    .pop_vld_o  (evt_valid_o),
    .count_o    (evt_count_o)
  );

  assign unused_head_key = ^head.key;
  assign keys_o          = keys_q;
  assign evt_key_o       = head.key[KEY_W-1:0];
  assign evt_pressed_o   = head.pressed;
  assign evt_lost_o      = lost_q;

endmodule

// File: tb/tb_key_debounce_events.sv
// Bench for key_debounce_events: directed key patterns, events checked by a scoreboard monitor.
`timescale 1ns/1ps
module tb_key_debounce_events;
  import nyan_keys_pkg::*;

  localparam int KEYS  = 4;
  localparam int DEB   = 8;
  localparam int SYNC  = 2;
  localparam int DEPTH = 4;
  localparam int LAT   = SYNC + DEB;

  typedef struct {
    int key;
    int pressed;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [3:0] keys_i, keys_o;
  logic       evt_valid_o, evt_ready_i, evt_pressed_o, evt_lost_o, lost_clr_i;
  logic [1:0] evt_key_o;
  logic [2:0] evt_count_o;

  logic [3:0] al_keys_i, al_keys_o;
  logic       al_valid_o, al_ready_i, al_pressed_o, al_lost_o, al_clr_i;
  logic [1:0] al_key_o;
  logic [2:0] al_count_o;

  int   checks = 0;
  int   errors = 0;
  int   cyc;
  exp_t exp_q[$];
  exp_t mon_e;

  key_debounce_events #(
    .KEYS(KEYS), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .keys_i(keys_i), .keys_o(keys_o),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_key_o(evt_key_o),
    .evt_pressed_o(evt_pressed_o), .evt_count_o(evt_count_o), .evt_lost_o(evt_lost_o),
    .lost_clr_i(lost_clr_i)
  );

  key_debounce_events #(
    .KEYS(KEYS), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk_i(clk_i), .rst_ni(rst_ni), .keys_i(al_keys_i), .keys_o(al_keys_o),
    .evt_valid_o(al_valid_o), .evt_ready_i(al_ready_i), .evt_key_o(al_key_o),
    .evt_pressed_o(al_pressed_o), .evt_count_o(al_count_o), .evt_lost_o(al_lost_o),
    .lost_clr_i(al_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Mirrors the scan pointer phase: both start at 0 and advance every clock after reset.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(negedge clk_i) begin
    if (rst_ni && evt_valid_o && evt_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL evt_unexpected: got key=%0d pressed=%0d, required no event", evt_key_o, evt_pressed_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(evt_key_o) != mon_e.key || int'(evt_pressed_o) != mon_e.pressed) begin
          errors++;
          $display("FAIL evt_order: got key=%0d pressed=%0d, required key=%0d pressed=%0d",
                   evt_key_o, evt_pressed_o, mon_e.key, mon_e.pressed);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic expect_evt(input int key, input int pressed);
    exp_t e;
    e.key     = key;
    e.pressed = pressed;
    exp_q.push_back(e);
  endtask

  // Keys that settle on the same clock are pushed in ring order starting at the pointer phase.
  task automatic expect_scan(input logic [3:0] mask, input logic [3:0] lvl, input int phase);
    for (int i = 0; i < KEYS; i++) begin
      int k;
      k = (phase + i) % KEYS;
      if (mask[k]) expect_evt(k, (lvl[k] == PRESS) ? 1 : 0);
    end
  endtask

  task automatic apply_keys(input logic [3:0] v);
    expect_scan(keys_i ^ v, v, (cyc + LAT) % KEYS);
    keys_i = v;
  endtask

  task automatic align(input int ph);
    for (int i = 0; i < KEYS && (cyc % KEYS) != ph; i++) tick(1);
  endtask

  initial begin
    rst_ni      = 1'b0;
    keys_i      = 4'b1111;
    evt_ready_i = 1'b1;
    lost_clr_i  = 1'b0;
    al_keys_i   = 4'b1111;
    al_ready_i  = 1'b0;
    al_clr_i    = 1'b0;
    tick(3);
    check("rst_keys_o", keys_o, 0);
    check("rst_valid", evt_valid_o, 0);
    check("rst_count", evt_count_o, 0);
    check("rst_lost", evt_lost_o, 0);

    // Keys held through reset settle 10 clocks after release, pointer then at phase 2: 2,3,0,1.
    expect_scan(4'b1111, 4'b1111, LAT % KEYS);
    rst_ni = 1'b1;
    tick(LAT - 1);
    check("rst_lat_pre", keys_o, 0);
    tick(1);
    check("rst_lat", keys_o, 4'b1111);
    tick(12);
    check("rst_drained", evt_count_o, 0);
    check("al_idle", al_count_o, 0);

    apply_keys(4'b0000);
    tick(20);
    check("release_all", keys_o, 0);

    keys_i = 4'b0100;
    tick(DEB - 1);
    keys_i = 4'b0000;
    tick(20);
    check("glitch_keys", keys_o, 0);
    check("glitch_count", evt_count_o, 0);

    apply_keys(4'b0100);
    tick(LAT - 1);
    check("hold_pre", keys_o, 0);
    tick(1);
    check("hold_lat", keys_o, 4'b0100);
    tick(10);
    apply_keys(4'b0000);
    tick(20);
    check("hold_release", keys_o, 0);
    check("hold_drained", evt_count_o, 0);

    // Settle lands on phase 0, so the queue fills in order 0,1,2,3.
    evt_ready_i = 1'b0;
    align(2);
    keys_i = 4'b1111;
    for (int k = 0; k < KEYS; k++) expect_evt(k, 1);
    tick(LAT + KEYS + 2);
    check("simul_full", evt_count_o, 4);
    check("simul_valid", evt_valid_o, 1);
    check("simul_head_key", evt_key_o, 0);
    check("simul_head_pressed", evt_pressed_o, 1);

    keys_i = 4'b1101;
    tick(LAT + 2 * KEYS + 2);
    check("bp_keys", keys_o, 4'b1101);
    check("bp_lost", evt_lost_o, 0);
    check("bp_count", evt_count_o, 4);
    expect_evt(1, 0);
    evt_ready_i = 1'b1;
    tick(12);
    check("bp_drained", evt_count_o, 0);

    evt_ready_i = 1'b0;
    apply_keys(4'b0000);
    tick(20);
    apply_keys(4'b1000);
    tick(20);
    check("loss_full", evt_count_o, 4);
    keys_i = 4'b1001;
    tick(20);
    check("loss_first", evt_lost_o, 0);
    check("loss_keys", keys_o, 4'b1001);
    keys_i = 4'b1000;
    tick(20);
    check("loss_set", evt_lost_o, 1);
    keys_i = 4'b1001;
    tick(20);
    check("loss_sticky", evt_lost_o, 1);
    lost_clr_i = 1'b1;
    tick(1);
    lost_clr_i = 1'b0;
    check("loss_clr", evt_lost_o, 0);
    expect_evt(0, 1);
    evt_ready_i = 1'b1;
    tick(15);
    check("loss_drained", evt_count_o, 0);
    check("loss_final_keys", keys_o, 4'b1001);

    al_keys_i = 4'b0111;
    tick(LAT - 1);
    check("al_lat_pre", al_keys_o, 0);
    tick(1);
    check("al_lat", al_keys_o, 4'b1000);
    for (int i = 0; i < 2 * KEYS && !al_valid_o; i++) tick(1);
    check("al_valid", al_valid_o, 1);
    check("al_key", al_key_o, 3);
    check("al_pressed", al_pressed_o, 1);
    check("al_count", al_count_o, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
